// File: rtl/pic_priority_core.sv
// pic_priority_core: interrupt core of the PIC.
//   Holds the IRR/ISR/IMR register set, resolves priority in fully-nested or rotating
//   order, and sequences the two-pulse INTA handshake that returns the vector byte.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   ir_i                  request lines (already synchronised)
//   level_i               1 = level-triggered, 0 = rising-edge-triggered
//   aeoi_i, rot_aeoi_i    automatic EOI on second INTA, optional rotate on it
//   imr_we_i, imr_in_i    mask register write
//   eoi_ns_i, eoi_sp_i    non-specific / specific EOI strobes
//   eoi_rot_i, eoi_lvl_i  EOI rotate qualifier and specific level
//   base_vec_i            upper vector bits
//   inta_pulse_i          one-cycle strobe per INTA falling edge
//   int_o                 registered interrupt request
//   vector_o, vec_valid_o vector and its one-cycle valid strobe
//   irr_o, isr_o, imr_o   register readback
//   inta_phase_o          0 = idle, 1 = waiting for second INTA pulse
module pic_priority_core #(
  parameter int unsigned NUM_IR = 8,
  parameter int unsigned IDX_W  = $clog2(NUM_IR),
  parameter int unsigned VEC_W  = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_IR-1:0]      ir_i,
  input  logic                   level_i,
  input  logic                   aeoi_i,
  input  logic                   rot_aeoi_i,
  input  logic                   imr_we_i,
  input  logic [NUM_IR-1:0]      imr_in_i,
  input  logic                   eoi_ns_i,
  input  logic                   eoi_sp_i,
  input  logic                   eoi_rot_i,
  input  logic [IDX_W-1:0]       eoi_lvl_i,
  input  logic [VEC_W-IDX_W-1:0] base_vec_i,
  input  logic                   inta_pulse_i,
  output logic                   int_o,
  output logic [VEC_W-1:0]       vector_o,
  output logic                   vec_valid_o,
  output logic [NUM_IR-1:0]      irr_o,
  output logic [NUM_IR-1:0]      isr_o,
  output logic [NUM_IR-1:0]      imr_o,
  output logic [1:0]             inta_phase_o
);

  typedef enum logic [0:0] {StIdle, StAck1} phase_e;

  phase_e             phase_q, phase_d;
  logic [NUM_IR-1:0]  irr_q, irr_d, isr_q, isr_d, imr_q, imr_d, ir_prev_q;
  logic [IDX_W-1:0]   lp_q, lp_d, sel_q, sel_d;
  logic               spur_q, spur_d, int_q, int_d, vec_valid_q, vec_valid_d;
  logic [VEC_W-1:0]   vector_q, vector_d;

  // Returns {found, index} of the highest-priority set bit; priority runs lp+1, lp+2, ...
  function automatic logic [IDX_W:0] find_top(input logic [NUM_IR-1:0] v,
                                              input logic [IDX_W-1:0]  lp);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] lvl;
    res = '0;
    // Scan from lowest to highest priority so the last hit is the winner.
    for (int k = NUM_IR - 1; k >= 0; k--) begin
      lvl = lp + IDX_W'(k + 1);
      if (v[lvl]) res = {1'b1, lvl};
    end
    return res;
  endfunction

  logic [IDX_W:0]    cand_top, isr_top;
  logic              cand_vld, isr_vld;
  logic [IDX_W-1:0]  cand_idx, isr_idx, cand_rank, isr_rank;
  logic [NUM_IR-1:0] ack_clr, isr_set, eoi_clr;

  always_comb begin
    cand_top  = find_top(irr_q & ~imr_q, lp_q);
    isr_top   = find_top(isr_q, lp_q);
    cand_vld  = cand_top[IDX_W];
    cand_idx  = cand_top[IDX_W-1:0];
    isr_vld   = isr_top[IDX_W];
    isr_idx   = isr_top[IDX_W-1:0];
    // Rank 0 is the highest priority level.
    cand_rank = cand_idx - lp_q - 1'b1;
    isr_rank  = isr_idx - lp_q - 1'b1;
  end

  always_comb begin
    phase_d     = phase_q;
    lp_d        = lp_q;
    sel_d       = sel_q;
    spur_d      = spur_q;
    vector_d    = vector_q;
    vec_valid_d = 1'b0;
    ack_clr     = '0;
    isr_set     = '0;
    eoi_clr     = '0;

    // EOI with an empty ISR has no effect at all, including rotation.
    if (isr_q != '0) begin
      if (eoi_sp_i) begin
        eoi_clr[eoi_lvl_i] = 1'b1;
        if (eoi_rot_i) lp_d = eoi_lvl_i;
      end else if (eoi_ns_i) begin
        eoi_clr[isr_idx] = 1'b1;
        if (eoi_rot_i) lp_d = isr_idx;
      end
    end

    unique case (phase_q)
      StIdle: begin
        if (inta_pulse_i) begin
          phase_d = StAck1;
          if (cand_vld) begin
            sel_d            = cand_idx;
            spur_d           = 1'b0;
            isr_set[cand_idx] = 1'b1;
            ack_clr[cand_idx] = 1'b1;
          end else begin
            sel_d  = IDX_W'(NUM_IR - 1);
            spur_d = 1'b1;
          end
        end
      end
      StAck1: begin
        if (inta_pulse_i) begin
          phase_d     = StIdle;
          vector_d    = {base_vec_i, sel_q};
          vec_valid_d = 1'b1;
          if (aeoi_i && !spur_q) begin
            eoi_clr[sel_q] = 1'b1;
            if (rot_aeoi_i) lp_d = sel_q;
          end
        end
      end
      default: phase_d = StIdle;
    endcase

    // EOI clears first, then the newly acknowledged level is set.
    isr_d = (isr_q & ~eoi_clr) | isr_set;
    // New requests win over the acknowledge clear.
    irr_d = level_i ? ir_i : ((irr_q & ~ack_clr) | (ir_i & ~ir_prev_q));
    imr_d = imr_we_i ? imr_in_i : imr_q;
    // Forced low on the first INTA so INT drops on the very next cycle.
    int_d = cand_vld && (!isr_vld || (cand_rank < isr_rank)) &&
            !((phase_q == StIdle) && inta_pulse_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q     <= StIdle;
      irr_q       <= '0;
      isr_q       <= '0;
      imr_q       <= '0;
      ir_prev_q   <= '0;
      lp_q        <= IDX_W'(NUM_IR - 1);
      sel_q       <= '0;
      spur_q      <= 1'b0;
      int_q       <= 1'b0;
      vector_q    <= '0;
      vec_valid_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      irr_q       <= irr_d;
      isr_q       <= isr_d;
      imr_q       <= imr_d;
      ir_prev_q   <= ir_i;
      lp_q        <= lp_d;
      sel_q       <= sel_d;
      spur_q      <= spur_d;
      int_q       <= int_d;
      vector_q    <= vector_d;
      vec_valid_q <= vec_valid_d;
    end
  end

  assign int_o        = int_q;
  assign vector_o     = vector_q;
  assign vec_valid_o  = vec_valid_q;
  assign irr_o        = irr_q;
  assign isr_o        = isr_q;
  assign imr_o        = imr_q;
  assign inta_phase_o = {1'b0, phase_q};

endmodule

// File: tb/tb_pic_priority_core.sv
// Directed bench for pic_priority_core (NUM_IR=8, base vector 0xA0).
module tb_pic_priority_core;

  logic       clk = 1'b0;
  logic       rst, level, aeoi, rot_aeoi, imr_we, eoi_ns, eoi_sp, eoi_rot, inta;
  logic [7:0] ir, imr_in;
  logic [2:0] eoi_lvl;
  logic [4:0] base_vec;
  logic       int_w, vec_valid;
  logic [7:0] vector, irr, isr, imr;
  logic [1:0] phase;

  int total = 0;
  int bad   = 0;

  pic_priority_core #(.NUM_IR(8), .IDX_W(3), .VEC_W(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .ir_i        (ir),
    .level_i     (level),
    .aeoi_i      (aeoi),
    .rot_aeoi_i  (rot_aeoi),
    .imr_we_i    (imr_we),
    .imr_in_i    (imr_in),
    .eoi_ns_i    (eoi_ns),
    .eoi_sp_i    (eoi_sp),
    .eoi_rot_i   (eoi_rot),
    .eoi_lvl_i   (eoi_lvl),
    .base_vec_i  (base_vec),
    .inta_pulse_i(inta),
    .int_o       (int_w),
    .vector_o    (vector),
    .vec_valid_o (vec_valid),
    .irr_o       (irr),
    .isr_o       (isr),
    .imr_o       (imr),
    .inta_phase_o(phase)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_inta();
    inta = 1'b1;
    cyc();
    inta = 1'b0;
  endtask

  task automatic pulse_eoi_ns();
    eoi_ns = 1'b1;
    cyc();
    eoi_ns = 1'b0;
  endtask

  initial begin
    rst = 1'b1; level = 1'b0; aeoi = 1'b0; rot_aeoi = 1'b0; imr_we = 1'b0; imr_in = '0;
    eoi_ns = 1'b0; eoi_sp = 1'b0; eoi_rot = 1'b0; eoi_lvl = '0; inta = 1'b0;
    ir = '0; base_vec = 5'h14;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_irr", irr, 0);
    chk("rst_isr", isr, 0);
    chk("rst_imr", imr, 0);
    chk("rst_int", int_w, 0);
    chk("rst_vec", vector, 0);
    chk("rst_vld", vec_valid, 0);
    chk("rst_phase", phase, 0);

    // T1: edge on IR3
    ir = 8'h08;
    cyc();
    chk("t1_irr", irr, 8'h08);
    chk("t1_int_t1", int_w, 0);
    cyc();
    chk("t1_int_t2", int_w, 1);
    pulse_inta();
    chk("t1_phase", phase, 1);
    chk("t1_isr", isr, 8'h08);
    chk("t1_irr_clr", irr, 8'h00);
    chk("t1_int_drop", int_w, 0);
    pulse_inta();
    chk("t1_vld", vec_valid, 1);
    chk("t1_vec", vector, 8'hA3);
    chk("t1_phase_idle", phase, 0);
    cyc();
    chk("t1_vld_one", vec_valid, 0);
    pulse_eoi_ns();
    chk("t1_eoi", isr, 8'h00);
    ir = 8'h00;
    cyc();

    // T2: IR5 and IR2 together, fully nested
    ir = 8'h24;
    cyc();
    chk("t2_irr", irr, 8'h24);
    cyc();
    chk("t2_int", int_w, 1);
    pulse_inta();
    chk("t2_isr", isr, 8'h04);
    chk("t2_irr_left", irr, 8'h20);
    cyc();
    chk("t2_blocked", int_w, 0);
    pulse_inta();
    chk("t2_vec", vector, 8'hA2);
    cyc();
    chk("t2_still_blocked", int_w, 0);
    pulse_eoi_ns();
    chk("t2_eoi_isr", isr, 8'h00);
    cyc();
    chk("t2_int_again", int_w, 1);
    pulse_inta();
    pulse_inta();
    chk("t2_vec5", vector, 8'hA5);
    chk("t2_isr5", isr, 8'h20);
    pulse_eoi_ns();
    chk("t2_eoi5", isr, 8'h00);
    ir = 8'h00;
    cyc();

    // T3: AEOI with rotation
    aeoi = 1'b1; rot_aeoi = 1'b1;
    ir = 8'h01;
    cyc(); cyc();
    chk("t3_int", int_w, 1);
    pulse_inta();
    chk("t3_isr", isr, 8'h01);
    pulse_inta();
    chk("t3_vec0", vector, 8'hA0);
    chk("t3_aeoi", isr, 8'h00);
    ir = 8'h00;
    cyc();
    ir = 8'h03;
    cyc();
    chk("t3_irr", irr, 8'h03);
    cyc();
    chk("t3_int2", int_w, 1);
    pulse_inta();
    chk("t3_rot_isr", isr, 8'h02);
    chk("t3_rot_irr", irr, 8'h01);
    pulse_inta();
    chk("t3_vec1", vector, 8'hA1);
    chk("t3_aeoi2", isr, 8'h00);
    cyc(); cyc();
    chk("t3_int_ir0", int_w, 1);
    pulse_inta();
    pulse_inta();
    chk("t3_vec0b", vector, 8'hA0);
    aeoi = 1'b0; rot_aeoi = 1'b0;
    ir = 8'h00;
    cyc();

    // T4: spurious acknowledge
    chk("t4_irr_empty", irr, 8'h00);
    pulse_inta();
    chk("t4_phase", phase, 1);
    chk("t4_isr", isr, 8'h00);
    pulse_inta();
    chk("t4_vld", vec_valid, 1);
    chk("t4_vec", vector, 8'hA7);
    chk("t4_isr2", isr, 8'h00);

    // T5: masking, and specific EOI with an empty ISR
    imr_in = 8'h10; imr_we = 1'b1;
    cyc();
    imr_we = 1'b0;
    chk("t5_imr", imr, 8'h10);
    ir = 8'h10;
    cyc();
    chk("t5_irr", irr, 8'h10);
    cyc();
    chk("t5_masked", int_w, 0);
    cyc();
    chk("t5_masked2", int_w, 0);
    imr_in = 8'h00; imr_we = 1'b1;
    cyc();
    imr_we = 1'b0;
    chk("t5_imr0", imr, 8'h00);
    chk("t5_int_lag", int_w, 0);
    cyc();
    chk("t5_int", int_w, 1);
    eoi_sp = 1'b1; eoi_lvl = 3'd6;
    cyc();
    eoi_sp = 1'b0;
    chk("t5_eoi_isr", isr, 8'h00);
    chk("t5_eoi_irr", irr, 8'h10);

    // T6: reset in ACK1
    pulse_inta();
    chk("t6_phase", phase, 1);
    chk("t6_isr", isr, 8'h10);
    rst = 1'b1; inta = 1'b1;
    cyc();
    rst = 1'b0; inta = 1'b0; ir = 8'h00;
    chk("t6_phase_rst", phase, 0);
    chk("t6_vld", vec_valid, 0);
    chk("t6_isr_rst", isr, 0);
    chk("t6_irr_rst", irr, 0);
    chk("t6_int_rst", int_w, 0);
    chk("t6_vec_rst", vector, 0);

    // Level-triggered IRR follows IR
    level = 1'b1;
    ir = 8'h02;
    cyc();
    chk("lvl_set", irr, 8'h02);
    ir = 8'h00;
    cyc();
    chk("lvl_clr", irr, 8'h00);
    level = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
